// File: rtl/cla_pkg.sv
// cla_pkg: op_e encoding (ADD, ADC, SUB, SBC) and c0_of, the carry-in into segment 0
package cla_pkg;
  typedef enum logic [1:0] {ADD = 2'd0, ADC = 2'd1, SUB = 2'd2, SBC = 2'd3} op_e;
  function automatic logic c0_of(input op_e op, input logic cin);
    return op[0] ? cin : op[1];
  endfunction
endpackage

// File: rtl/cla_segment.sv
// cla_segment: SEG-bit carry-lookahead adder; a, b, ci -> s, co, c_msb (carry into the top bit)
module cla_segment #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co,
  output logic           c_msb
);
  logic [SEG-1:0] g, p;
  logic [SEG:0]   c;
  logic           t;
  always_comb begin
    g = a & b;
    p = a ^ b;
    c[0] = ci;
    t = 1'b1;
    for (int i = 0; i < SEG; i++) begin
      c[i+1] = 1'b0;
      t = 1'b1;
      for (int j = i; j >= 0; j--) begin
        c[i+1] = c[i+1] | (t & g[j]);
        t = t & p[j];
      end
      c[i+1] = c[i+1] | (t & ci);
    end
    s = p ^ c[SEG-1:0];
    co = c[SEG];
    c_msb = c[SEG-1];
  end
endmodule

// File: rtl/cla_pipe_alu.sv
// cla_pipe_alu: pipelined add/sub ALU, one CLA segment per stage; in_valid/in_ready/a/b/op/cin -> out_valid/out_ready/sum/cout/ovf
module cla_pipe_alu
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int STAGES = WIDTH / SEG;
  logic              adv;
  logic [STAGES-1:0] v_q, v_d, c_q, c_d, c_p;
  logic              ovf_q, ovf_d;
  logic [WIDTH-1:0]  a_q [STAGES], a_d [STAGES], a_p [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES], b_d [STAGES], b_p [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES], s_d [STAGES], s_p [STAGES];
  logic [SEG-1:0]    seg_s [STAGES];
  logic              seg_cm [STAGES];
  always_comb begin
    a_p[0] = a;
    b_p[0] = op[1] ? ~b : b;
    s_p[0] = '0;
    c_p = STAGES'({c_q, c0_of(op, cin)});
    for (int k = 1; k < STAGES; k++) begin
      a_p[k] = a_q[k-1];
      b_p[k] = b_q[k-1];
      s_p[k] = s_q[k-1];
    end
  end
  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    cla_segment #(.SEG(SEG)) u_seg (
      .a     (a_p[k][k*SEG +: SEG]),
      .b     (b_p[k][k*SEG +: SEG]),
      .ci    (c_p[k]),
      .s     (seg_s[k]),
      .co    (c_d[k]),
      .c_msb (seg_cm[k])
    );
  end
  always_comb begin
    adv = !v_q[STAGES-1] | out_ready;
    v_d = STAGES'({v_q, in_valid});
    ovf_d = c_d[STAGES-1] ^ seg_cm[STAGES-1];
    for (int k = 0; k < STAGES; k++) begin
      a_d[k] = a_p[k];
      b_d[k] = b_p[k];
      s_d[k] = s_p[k];
      s_d[k][k*SEG +: SEG] = seg_s[k];
    end
    in_ready = adv;
    out_valid = v_q[STAGES-1];
    sum = s_q[STAGES-1];
    cout = c_q[STAGES-1];
    ovf = ovf_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      c_q <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (adv) begin
      v_q <= v_d;
      c_q <= c_d;
      ovf_q <= ovf_d;
      a_q <= a_d;
      b_q <= b_d;
      s_q <= s_d;
    end
  end
endmodule

// File: tb/tb_cla_pipe_alu.sv
// tb_cla_pipe_alu: randomized and directed checks of cla_pipe_alu against an integer arithmetic model
module tb_cla_pipe_alu;
  import cla_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int vectors = 0;
  int miscompares = 0;
  typedef struct packed {
    logic        ovf;
    logic        cout;
    logic [31:0] sum;
  } res_t;
  function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic [1:0] op, input logic cin);
    longint m, ua, ubx, c0, t, half, sa, sb, sr;
    res_t r;
    m = longint'(1) << w;
    ua = longint'(a) % m;
    ubx = op[1] ? (m - 1 - longint'(b) % m) : longint'(b) % m;
    c0 = (op == 2'd0) ? 0 : (op == 2'd2) ? 1 : longint'(cin);
    t = ua + ubx + c0;
    r.sum = 32'(t % m);
    r.cout = (t >= m);
    half = m / 2;
    sa = (ua >= half) ? ua - m : ua;
    sb = (ubx >= half) ? ubx - m : ubx;
    sr = sa + sb + c0;
    r.ovf = (sr >= half) || (sr < -half);
    return r;
  endfunction
  logic        in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;
  op_e         op;
  res_t        exp_q[$];
  cla_pipe_alu #(.WIDTH(16), .SEG(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .op(op),
    .cin(cin), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );
  logic       iv8, ir8, cin8, ov8, or8, co8, of8;
  logic [7:0] a8, b8, s8;
  op_e        op8;
  cla_pipe_alu #(.WIDTH(8), .SEG(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .op(op8),
    .cin(cin8), .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .ovf(of8)
  );
  logic        iv12, ir12, cin12, ov12, or12, co12, of12;
  logic [11:0] a12, b12, s12;
  op_e         op12;
  cla_pipe_alu #(.WIDTH(12), .SEG(3)) dut12 (
    .clk(clk), .rst(rst), .in_valid(iv12), .in_ready(ir12), .a(a12), .b(b12), .op(op12),
    .cin(cin12), .out_valid(ov12), .out_ready(or12), .sum(s12), .cout(co12), .ovf(of12)
  );

  task automatic test_reset();
    in_valid = 0; out_ready = 0; a = 0; b = 0; op = ADD; cin = 0;
    iv8 = 0; or8 = 0; a8 = 0; b8 = 0; op8 = ADD; cin8 = 0;
    iv12 = 0; or12 = 0; a12 = 0; b12 = 0; op12 = ADD; cin12 = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    vectors++;
    if ({ovf, cout, sum} !== 18'h0) begin miscompares++; $display("FAIL reset_outputs got %h exp 0", {ovf, cout, sum}); end
    vectors++;
    if ({ov8, ov12} !== 2'b00) begin miscompares++; $display("FAIL reset_aux_valid got %b exp 00", {ov8, ov12}); end
    rst = 0;
    @(negedge clk);
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_latency();
    int lat;
    logic [17:0] got;
    lat = 0;
    got = '0;
    @(negedge clk);
    a = 16'h00FF; b = 16'h0001; op = ADD; cin = 0; in_valid = 1; out_ready = 1;
    for (int c = 1; c <= 12 && lat == 0; c++) begin
      @(negedge clk);
      in_valid = 0;
      #1;
      if (out_valid) begin lat = c; got = {ovf, cout, sum}; end
    end
    vectors++;
    if (lat !== 4) begin miscompares++; $display("FAIL latency got %0d exp 4", lat); end
    vectors++;
    if (got !== 18'h00100) begin miscompares++; $display("FAIL latency_result got %h exp 00100", got); end
  endtask

  task automatic test_directed();
    logic [15:0] ta [5] = '{16'h7FFF, 16'h0000, 16'hFFFF, 16'h0005, 16'h8000};
    logic [15:0] tb [5] = '{16'h0001, 16'h0001, 16'h0000, 16'h0003, 16'h0001};
    op_e         to [5] = '{ADD, SUB, ADC, SBC, SUB};
    logic        tc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [17:0] te [5] = '{18'h28000, 18'h0FFFF, 18'h10000, 18'h10001, 18'h37FFF};
    logic        got_v;
    logic [17:0] got;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = ta[i]; b = tb[i]; op = to[i]; cin = tc[i]; in_valid = 1; out_ready = 1;
      got_v = 0;
      got = '0;
      for (int c = 0; c < 12 && !got_v; c++) begin
        @(negedge clk);
        in_valid = 0;
        #1;
        if (out_valid) begin got_v = 1; got = {ovf, cout, sum}; end
      end
      vectors++;
      if (!got_v || got !== te[i]) begin
        miscompares++;
        $display("FAIL directed_%0d got valid=%b {ovf,cout,sum}=%h exp %h", i, got_v, got, te[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [8], vb [8];
    op_e         vo [8];
    logic        vc [8];
    logic [18:0] held;
    logic        held_v;
    int          idx, rcv;
    res_t        e;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      va[i] = 16'($urandom); vb[i] = 16'($urandom); vo[i] = op_e'($urandom_range(0, 3)); vc[i] = 1'($urandom);
    end
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      out_ready = 1;
      in_valid = (c < 8);
      if (c < 8) begin a = va[c]; b = vb[c]; op = vo[c]; cin = vc[c]; end
      #1;
      vectors++;
      if (out_valid !== (c >= 4 && c < 12)) begin
        miscompares++; $display("FAIL b2b_valid_cycle%0d got %b exp %b", c, out_valid, (c >= 4 && c < 12));
      end
      if (out_valid) begin
        vectors++;
        if (exp_q.size() == 0) begin miscompares++; $display("FAIL b2b_extra got %h exp none", sum); end
        else begin
          e = exp_q.pop_front();
          if ({ovf, cout, sum} !== {e.ovf, e.cout, e.sum[15:0]}) begin
            miscompares++; $display("FAIL b2b_data got %h exp %h", {ovf, cout, sum}, {e.ovf, e.cout, e.sum[15:0]});
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(16, 32'(a), 32'(b), op, cin));
    end
    for (int i = 0; i < 8; i++) begin
      va[i] = 16'($urandom); vb[i] = 16'($urandom); vo[i] = op_e'($urandom_range(0, 3)); vc[i] = 1'($urandom);
    end
    exp_q.delete();
    idx = 0; rcv = 0; held_v = 0; held = '0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      out_ready = !(c >= 6 && c < 9);
      in_valid = (idx < 8);
      if (idx < 8) begin a = va[idx]; b = vb[idx]; op = vo[idx]; cin = vc[idx]; end
      #1;
      if (held_v) begin
        vectors++;
        if ({out_valid, ovf, cout, sum} !== held) begin
          miscompares++; $display("FAIL stall_hold got %h exp %h", {out_valid, ovf, cout, sum}, held);
        end
      end
      if (out_valid && !out_ready) begin
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_in_ready got %b exp 0", in_ready); end
      end
      held_v = out_valid && !out_ready;
      held = {out_valid, ovf, cout, sum};
      if (out_valid && out_ready) begin
        rcv++;
        vectors++;
        if (exp_q.size() == 0) begin miscompares++; $display("FAIL stall_extra got %h exp none", sum); end
        else begin
          e = exp_q.pop_front();
          if ({ovf, cout, sum} !== {e.ovf, e.cout, e.sum[15:0]}) begin
            miscompares++; $display("FAIL stall_data got %h exp %h", {ovf, cout, sum}, {e.ovf, e.cout, e.sum[15:0]});
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(16, 32'(a), 32'(b), op, cin));
        idx++;
      end
    end
    vectors++;
    if (rcv !== 8 || idx !== 8) begin miscompares++; $display("FAIL stall_count got sent=%0d rcvd=%0d exp 8/8", idx, rcv); end
  endtask

  task automatic test_reset_flush();
    res_t        e;
    logic        got_v;
    logic [17:0] got;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = 1; out_ready = 1; a = 16'($urandom); b = 16'($urandom); op = ADD; cin = 0;
    end
    @(negedge clk);
    in_valid = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_cycle%0d got out_valid=%b exp 0", c, out_valid); end
    end
    @(negedge clk);
    a = 16'h1234; b = 16'h0101; op = ADD; cin = 1; in_valid = 1;
    e = model(16, 32'h1234, 32'h0101, 2'd0, 1'b1);
    got_v = 0;
    got = '0;
    for (int c = 0; c < 12 && !got_v; c++) begin
      @(negedge clk);
      in_valid = 0;
      #1;
      if (out_valid) begin got_v = 1; got = {ovf, cout, sum}; end
    end
    vectors++;
    if (!got_v || got !== {e.ovf, e.cout, e.sum[15:0]}) begin
      miscompares++; $display("FAIL flush_next got valid=%b %h exp %h", got_v, got, {e.ovf, e.cout, e.sum[15:0]});
    end
  endtask

  task automatic test_random();
    res_t e;
    exp_q.delete();
    for (int c = 0; c < 440; c++) begin
      @(negedge clk);
      in_valid = (c < 400) && ($urandom_range(0, 3) != 0);
      out_ready = (c >= 400) || ($urandom_range(0, 3) != 0);
      a = 16'($urandom); b = 16'($urandom); op = op_e'($urandom_range(0, 3)); cin = 1'($urandom);
      #1;
      if (out_valid && out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin miscompares++; $display("FAIL rand16_extra got %h exp none", sum); end
        else begin
          e = exp_q.pop_front();
          if ({ovf, cout, sum} !== {e.ovf, e.cout, e.sum[15:0]}) begin
            miscompares++; $display("FAIL rand16 got %h exp %h", {ovf, cout, sum}, {e.ovf, e.cout, e.sum[15:0]});
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(16, 32'(a), 32'(b), op, cin));
    end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL rand16_lost got %0d pending exp 0", exp_q.size()); end
  endtask

  task automatic test_configs();
    res_t e;
    res_t q8[$];
    res_t q12[$];
    for (int c = 0; c < 340; c++) begin
      @(negedge clk);
      iv8 = (c < 300) && ($urandom_range(0, 3) != 0);
      or8 = (c >= 300) || ($urandom_range(0, 3) != 0);
      a8 = 8'($urandom); b8 = 8'($urandom); op8 = op_e'($urandom_range(0, 3)); cin8 = 1'($urandom);
      iv12 = (c < 300) && ($urandom_range(0, 3) != 0);
      or12 = (c >= 300) || ($urandom_range(0, 3) != 0);
      a12 = 12'($urandom); b12 = 12'($urandom); op12 = op_e'($urandom_range(0, 3)); cin12 = 1'($urandom);
      #1;
      if (ov8 && or8) begin
        vectors++;
        if (q8.size() == 0) begin miscompares++; $display("FAIL rand8_extra got %h exp none", s8); end
        else begin
          e = q8.pop_front();
          if ({of8, co8, s8} !== {e.ovf, e.cout, e.sum[7:0]}) begin
            miscompares++; $display("FAIL rand8 got %h exp %h", {of8, co8, s8}, {e.ovf, e.cout, e.sum[7:0]});
          end
        end
      end
      if (ov12 && or12) begin
        vectors++;
        if (q12.size() == 0) begin miscompares++; $display("FAIL rand12_extra got %h exp none", s12); end
        else begin
          e = q12.pop_front();
          if ({of12, co12, s12} !== {e.ovf, e.cout, e.sum[11:0]}) begin
            miscompares++; $display("FAIL rand12 got %h exp %h", {of12, co12, s12}, {e.ovf, e.cout, e.sum[11:0]});
          end
        end
      end
      if (iv8 && ir8) q8.push_back(model(8, 32'(a8), 32'(b8), op8, cin8));
      if (iv12 && ir12) q12.push_back(model(12, 32'(a12), 32'(b12), op12, cin12));
    end
    vectors++;
    if (q8.size() != 0 || q12.size() != 0) begin
      miscompares++; $display("FAIL rand_aux_lost got %0d/%0d pending exp 0/0", q8.size(), q12.size());
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_back_to_back();
    test_reset_flush();
    test_random();
    test_configs();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
